// File: rtl/game_sequencer_if.sv
// Board-side and datapath-side signals of the game sequencer, bundled for the top-level FSM.
// The master side drives buttons, draw completion and health; the slave side (the sequencer) drives the rest.
interface game_sequencer_if #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned HEALTH_W = 4,
    parameter int unsigned LEVEL_W  = 3
);
    logic                start_btn;
    logic                pause_btn;
    logic                draw_done;
    logic [HEALTH_W-1:0] ship_health;
    logic [X_W-1:0]      user_x;
    logic [X_W-1:0]      enemy_x;
    logic                writeEn;
    logic                shipUpdateEn;
    logic                gridUpdateEn;
    logic                gameOverEn;
    logic                paused;
    logic [LEVEL_W-1:0]  level;
    logic                tick;

    modport master (
        output start_btn, pause_btn, draw_done, ship_health,
        input  user_x, enemy_x, writeEn, shipUpdateEn, gridUpdateEn,
               gameOverEn, paused, level, tick
    );

    modport slave (
        input  start_btn, pause_btn, draw_done, ship_health,
        output user_x, enemy_x, writeEn, shipUpdateEn, gridUpdateEn,
               gameOverEn, paused, level, tick
    );
endinterface

// File: rtl/game_sequencer.sv
// Top-level game FSM: frame-tick divider that speeds up with level, start/draw/update/wait
// sequencing with a draw-done handshake, pause toggling and a timed game-over screen.
module game_sequencer #(
    parameter int unsigned CLK_DIV        = 3125000,
    parameter int unsigned X_W            = 8,
    parameter int unsigned X_START        = 80,
    parameter int unsigned HEALTH_W       = 4,
    parameter int unsigned LEVEL_W        = 3,
    parameter int unsigned LEVEL_TICKS    = 256,
    parameter int unsigned GAMEOVER_TICKS = 32
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    game_sequencer_if.slave bus
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned UPD_W = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
    localparam int unsigned GO_W  = (GAMEOVER_TICKS > 1) ? $clog2(GAMEOVER_TICKS) : 1;

    localparam logic [DIV_W-1:0]   DIV_RESET = DIV_W'(CLK_DIV - 32'd1);
    localparam logic [UPD_W-1:0]   UPD_LAST  = UPD_W'(LEVEL_TICKS - 32'd1);
    localparam logic [GO_W-1:0]    GO_LAST   = GO_W'(GAMEOVER_TICKS - 32'd1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};
    localparam logic [X_W-1:0]     X_INIT    = X_W'(X_START);

    typedef enum logic [2:0] {
        S_START    = 3'd0,
        S_DRAW     = 3'd1,
        S_UPDATE   = 3'd2,
        S_WAIT     = 3'd3,
        S_PAUSE    = 3'd4,
        S_GAMEOVER = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [UPD_W-1:0]   upd_cnt_q, upd_cnt_d;
    logic [GO_W-1:0]    go_cnt_q, go_cnt_d;
    logic               start_latch_q, start_latch_d;
    logic               pause_q;
    logic [X_W-1:0]     user_x_q, user_x_d, enemy_x_q, enemy_x_d;
    logic               write_en_q, ship_upd_q, grid_upd_q, game_over_q, paused_q, tick_q;

    logic [31:0]        shifted_s;
    logic [DIV_W-1:0]   period_m1_s;
    logic               frozen_s, tick_s, pause_rise_s;

    // Reload value for the divider: the base period halves per level, floored at two clocks.
    always_comb begin
        shifted_s = 32'(CLK_DIV) >> level_q;
        if (shifted_s < 32'd2) begin
            period_m1_s = DIV_W'(32'd1);
        end else begin
            period_m1_s = DIV_W'(shifted_s - 32'd1);
        end
    end

    assign frozen_s     = (state_q == S_PAUSE) || (state_q == S_DRAW);
    assign tick_s       = !frozen_s && (div_q == '0);
    assign pause_rise_s = bus.pause_btn & ~pause_q;

    // Next-state, divider and counter updates for the current state.
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        upd_cnt_d     = upd_cnt_q;
        go_cnt_d      = go_cnt_q;
        start_latch_d = start_latch_q;
        user_x_d      = user_x_q;
        enemy_x_d     = enemy_x_q;

        if (frozen_s) begin
            div_d = div_q;
        end else if (div_q == '0) begin
            div_d = period_m1_s;
        end else begin
            div_d = div_q - DIV_W'(1'b1);
        end

        case (state_q)
            S_START: begin
                if (bus.start_btn) begin
                    start_latch_d = 1'b1;
                end else begin
                    start_latch_d = start_latch_q;
                end
                if (tick_s && (start_latch_q || bus.start_btn)) begin
                    state_d       = S_DRAW;
                    start_latch_d = 1'b0;
                    level_d       = '0;
                    upd_cnt_d     = '0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DRAW: begin
                if (bus.draw_done) begin
                    state_d = S_UPDATE;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_UPDATE: begin
                state_d = S_WAIT;
                if (upd_cnt_q == UPD_LAST) begin
                    upd_cnt_d = '0;
                    if (level_q != LEVEL_MAX) begin
                        level_d = level_q + LEVEL_W'(1'b1);
                    end else begin
                        level_d = level_q;
                    end
                end else begin
                    upd_cnt_d = upd_cnt_q + UPD_W'(1'b1);
                end
            end
            S_WAIT: begin
                if (bus.ship_health == '0) begin
                    state_d = S_GAMEOVER;
                end else if (pause_rise_s) begin
                    state_d = S_PAUSE;
                end else if (tick_s) begin
                    state_d = S_DRAW;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_PAUSE: begin
                if (pause_rise_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_GAMEOVER: begin
                if (tick_s && (go_cnt_q == GO_LAST)) begin
                    state_d   = S_START;
                    go_cnt_d  = '0;
                    user_x_d  = X_INIT;
                    enemy_x_d = X_INIT;
                end else if (tick_s) begin
                    state_d  = S_GAMEOVER;
                    go_cnt_d = go_cnt_q + GO_W'(1'b1);
                end else begin
                    state_d = S_GAMEOVER;
                end
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    // State and counter registers; Moore outputs are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q       <= S_START;
            div_q         <= DIV_RESET;
            level_q       <= '0;
            upd_cnt_q     <= '0;
            go_cnt_q      <= '0;
            start_latch_q <= 1'b0;
            pause_q       <= 1'b0;
            user_x_q      <= X_INIT;
            enemy_x_q     <= X_INIT;
            write_en_q    <= 1'b1;
            ship_upd_q    <= 1'b0;
            grid_upd_q    <= 1'b0;
            game_over_q   <= 1'b0;
            paused_q      <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            level_q       <= level_d;
            upd_cnt_q     <= upd_cnt_d;
            go_cnt_q      <= go_cnt_d;
            start_latch_q <= start_latch_d;
            pause_q       <= bus.pause_btn;
            user_x_q      <= user_x_d;
            enemy_x_q     <= enemy_x_d;
            write_en_q    <= (state_d == S_START) || (state_d == S_DRAW);
            ship_upd_q    <= (state_d == S_UPDATE);
            grid_upd_q    <= (state_d == S_UPDATE);
            game_over_q   <= (state_d == S_GAMEOVER);
            paused_q      <= (state_d == S_PAUSE);
            tick_q        <= (div_d == '0) && (state_d != S_PAUSE) && (state_d != S_DRAW);
        end
    end

    assign bus.user_x       = user_x_q;
    assign bus.enemy_x      = enemy_x_q;
    assign bus.writeEn      = write_en_q;
    assign bus.shipUpdateEn = ship_upd_q;
    assign bus.gridUpdateEn = grid_upd_q;
    assign bus.gameOverEn   = game_over_q;
    assign bus.paused       = paused_q;
    assign bus.level        = level_q;
    assign bus.tick         = tick_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer with CLK_DIV=8, LEVEL_TICKS=4, GAMEOVER_TICKS=2, LEVEL_W=2: a vector
// table through a scoreboard queue for reset/start, then hand-written level, pause, gameover and reset sequences.
module tb_game_sequencer;
    localparam int X_W      = 8;
    localparam int HEALTH_W = 4;
    localparam int LEVEL_W  = 2;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    game_sequencer_if #(.X_W(X_W), .HEALTH_W(HEALTH_W), .LEVEL_W(LEVEL_W)) bus ();

    game_sequencer #(
        .CLK_DIV(8), .X_W(X_W), .X_START(80), .HEALTH_W(HEALTH_W),
        .LEVEL_W(LEVEL_W), .LEVEL_TICKS(4), .GAMEOVER_TICKS(2)
    ) dut (
        .clk_i(clk),
        .reset_ni(reset_n),
        .bus(bus)
    );

    typedef struct packed {
        logic       we;
        logic       su;
        logic       gu;
        logic       go;
        logic       pz;
        logic       tk;
        logic [1:0] lvl;
    } obs_t;

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       pause;
        logic       dd;
        logic [3:0] health;
        obs_t       exp;
    } vec_t;

    vec_t vecs [14];
    obs_t sb_q [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic obs_t ob(logic we, logic su, logic gu, logic go, logic pz, logic tk, int lvl);
        return {we, su, gu, go, pz, tk, 2'(lvl)};
    endfunction

    function automatic vec_t mk(logic r, logic s, logic p, logic d, int h, obs_t e);
        vec_t v;
        v.rst_n = r; v.start = s; v.pause = p; v.dd = d; v.health = 4'(h); v.exp = e;
        return v;
    endfunction

    function automatic obs_t sample();
        return {bus.writeEn, bus.shipUpdateEn, bus.gridUpdateEn, bus.gameOverEn,
                bus.paused, bus.tick, bus.level};
    endfunction

    // Divider period for a level: 8 halved per level, floored at 2.
    function automatic int per(int l);
        int p;
        p = 8 >> l;
        return (p < 2) ? 2 : p;
    endfunction

    task automatic check_obs(string name, obs_t act, obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got we/su/gu/go/pz/tk/lvl=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until tick is seen (0 if already high), or -1 past the budget.
    task automatic wait_tick(input int max, output int n);
        n = 0;
        while (bus.tick !== 1'b1 && n <= max) begin
            step();
            n++;
        end
        if (bus.tick !== 1'b1) n = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, exp_wait, u, exp_lvl, pload, bad;
        obs_t got, exp;

        reset_n         = 1'b0;
        bus.start_btn   = 1'b0;
        bus.pause_btn   = 1'b0;
        bus.draw_done   = 1'b0;
        bus.ship_health = 4'd5;

        // Reset with toggling inputs, countdown 7..0, start pulse mid-period, draw and update.
        vecs[0]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 0, ob(1, 0, 0, 0, 0, 0, 0));
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 0, ob(1, 0, 0, 0, 0, 0, 0));
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 0, ob(1, 0, 0, 0, 0, 0, 0));
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5, ob(1, 0, 0, 0, 0, 0, 0));
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5, ob(1, 0, 0, 0, 0, 0, 0));
        vecs[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 5, ob(1, 0, 0, 0, 0, 0, 0));
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5, ob(1, 0, 0, 0, 0, 0, 0));
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5, ob(1, 0, 0, 0, 0, 0, 0));
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5, ob(1, 0, 0, 0, 0, 0, 0));
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5, ob(1, 0, 0, 0, 0, 1, 0));
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 5, ob(1, 0, 0, 0, 0, 0, 0));
        vecs[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 5, ob(0, 1, 1, 0, 0, 0, 0));
        vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 5, ob(0, 0, 0, 0, 0, 0, 0));
        vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 5, ob(0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 14; i++) begin
            reset_n         = vecs[i].rst_n;
            bus.start_btn   = vecs[i].start;
            bus.pause_btn   = vecs[i].pause;
            bus.draw_done   = vecs[i].dd;
            bus.ship_health = vecs[i].health;
            sb_q.push_back(vecs[i].exp);
            step();
            got = sample();
            exp = sb_q.pop_front();
            check_obs($sformatf("vec%0d", i), got, exp);
        end
        check_int("user_x_after_start", int'(bus.user_x), 80);
        check_int("enemy_x_after_start", int'(bus.enemy_x), 80);

        // Eleven more frames with draw_done held; the DRAW cycle is frozen, so from WAIT the
        // next tick comes period-2 edges later, using the level in force at the previous reload.
        bus.draw_done = 1'b1;
        exp_wait = 5; u = 1; exp_lvl = 0;
        for (int k = 0; k < 11; k++) begin
            wait_tick(20, n);
            check_int($sformatf("frame%0d_tick_wait", k), n, exp_wait);
            pload = per(exp_lvl);
            step();
            check_obs($sformatf("frame%0d_draw", k), sample(), ob(1, 0, 0, 0, 0, 0, exp_lvl));
            step();
            check_obs($sformatf("frame%0d_update", k), sample(), ob(0, 1, 1, 0, 0, 0, exp_lvl));
            u++;
            exp_lvl = (u / 4 > 3) ? 3 : u / 4;
            step();
            check_obs($sformatf("frame%0d_wait", k), sample(),
                      ob(0, 0, 0, 0, 0, (pload == 2) ? 1'b1 : 1'b0, exp_lvl));
            exp_wait = pload - 2;
        end

        // Pause beats a pending tick; while paused nothing moves and zero health is ignored.
        bus.pause_btn = 1'b1;
        step();
        check_obs("pause_enter", sample(), ob(0, 0, 0, 0, 1, 0, 3));
        bad = 0;
        for (int j = 0; j < 50; j++) begin
            bus.pause_btn   = (j < 5) ? 1'b1 : 1'b0;
            bus.ship_health = (j >= 10 && j < 30) ? 4'd0 : 4'd5;
            step();
            if (sample() !== ob(0, 0, 0, 0, 1, 0, 3)) bad++;
        end
        check_int("pause_hold_bad_cycles", bad, 0);
        bus.pause_btn = 1'b1;
        step();
        check_obs("pause_exit", sample(), ob(0, 0, 0, 0, 0, 0, 3));
        bus.pause_btn = 1'b0;
        step();
        check_obs("pause_resume_tick", sample(), ob(0, 0, 0, 0, 0, 1, 3));

        // Zero health and a pause edge together in WAIT: game over wins, then two ticks to START.
        bus.ship_health = 4'd0;
        bus.pause_btn   = 1'b1;
        step();
        check_obs("gameover_enter", sample(), ob(0, 0, 0, 1, 0, 0, 3));
        bus.pause_btn = 1'b0;
        wait_tick(10, n);
        check_int("gameover_tick1_wait", n, 1);
        check_obs("gameover_tick1", sample(), ob(0, 0, 0, 1, 0, 1, 3));
        step();
        check_obs("gameover_mid", sample(), ob(0, 0, 0, 1, 0, 0, 3));
        wait_tick(10, n);
        check_int("gameover_tick2_wait", n, 1);
        step();
        check_obs("gameover_restart", sample(), ob(1, 0, 0, 0, 0, 0, 3));
        check_int("user_x_restart", int'(bus.user_x), 80);
        check_int("enemy_x_restart", int'(bus.enemy_x), 80);

        // Restart, then reset while DRAW waits on draw_done.
        bus.ship_health = 4'd5;
        bus.draw_done   = 1'b0;
        bus.start_btn   = 1'b1;
        step();
        check_obs("restart_tick", sample(), ob(1, 0, 0, 0, 0, 1, 3));
        bus.start_btn = 1'b0;
        step();
        check_obs("restart_draw", sample(), ob(1, 0, 0, 0, 0, 0, 0));
        step();
        check_obs("draw_held", sample(), ob(1, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b0;
        step();
        check_obs("reset_mid_draw", sample(), ob(1, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        wait_tick(20, n);
        check_int("reset_div_reload", n, 7);
        step();
        check_obs("no_start_after_reset", sample(), ob(1, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
